pci_target_ctrl: RTL
====================

// Module: pci_target_ctrl
// PURPOSE
//  PCI target-side sequencer for one sram_32 instance. Decodes PCI address phases against the SRAM
//  word window and drives DEVSEL#/TRDY#/STOP#. Converts burst memory read/write data phases into
//  SRAM word accesses, incrementing the address, and disconnects at the window end.
// PARAMETERS
//  ADD_START  30'h0000_0000  first word address (AD[31:2]) claimed; same value as the SRAM add_start
//  ADD_END    30'h0000_03FF  last word address claimed; same value as the SRAM add_end
// PORTS
//  clk           in   1   single clock; all outputs registered on posedge
//  rst_n         in   1   asynchronous active-low reset
//  frame_n       in   1   PCI FRAME#
//  irdy_n        in   1   PCI IRDY#
//  cbe_n         in   4   command in address phase, byte enables (active low) in data phase
//  ad_in         in   32  PCI AD bus as sampled
//  ad_out        out  32  read data to the AD bus
//  ad_oe         out  1   1 = target drives AD (read data phases only)
//  devsel_n      out  1   PCI DEVSEL#
//  trdy_n        out  1   PCI TRDY#
//  stop_n        out  1   PCI STOP#
//  sram_add      out  32  SRAM byte address = {word_addr,2'b00}
//  sram_data     out  32  SRAM write data
//  sram_be       out  4   SRAM byte enables (active high) = ~cbe_n
//  sram_we       out  1   SRAM write strobe, exactly 1 clk per completed write data phase
//  sram_q        in   32  SRAM data_out; registered, valid 1 clk after sram_add is presented
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; devsel_n=trdy_n=stop_n=1, ad_oe=0, sram_we=0,
//   ad_out=0, sram_add=0, sram_data=0, sram_be=0. Reset mid-burst aborts at once; no partial write.
//  addr: 30-bit word counter. Disconnect rule: addr==ADD_END, no wrap past the window.
//  Address phase: in IDLE on an edge with frame_n=0 and frame_n=1 on the previous edge.
//   Latch addr=ad_in[31:2] and cmd=cbe_n. Hit = cmd in {4'b0110 MemRd, 4'b0111 MemWr}
//   and ADD_START<=addr<=ADD_END.
//   Miss -> BUSY; outputs stay idle; return to IDLE on the first edge with frame_n=1 & irdy_n=1.
//  States: IDLE, WR_DATA, RD_W1, RD_W2, RD_DATA, STOP_WAIT, TURN, BUSY.
//  Write hit (same edge): devsel_n<=0, trdy_n<=0; stop_n<=0 if addr==ADD_END. -> WR_DATA.
//  WR_DATA: a phase completes on an edge with irdy_n=0 (trdy_n is already 0). That edge:
//   sram_we<=1, sram_add<={addr,2'b00}, sram_data<=ad_in, sram_be<=~cbe_n; addr<=addr+1.
//   Other edges: sram_we<=0. Then:
//    - frame_n=1 at completion -> TURN
//    - else addr==ADD_END -> STOP_WAIT
//    - else, when addr+1==ADD_END, stop_n<=0 so STOP# goes with the final TRDY#.
//  Read hit (same edge): devsel_n<=0, sram_add<={addr,2'b00}, ad_oe<=1. -> RD_W1 -> RD_W2.
//   RD_W2 edge: ad_out<=sram_q, trdy_n<=0; stop_n<=0 if addr==ADD_END. -> RD_DATA.
//  RD_DATA: a phase completes on an edge with irdy_n=0. That edge: trdy_n<=1; then:
//    - frame_n=1 -> TURN
//    - addr==ADD_END -> STOP_WAIT
//    - else addr<=addr+1, sram_add<=next, -> RD_W1 (3 clk per read word)
//   irdy_n=1 wait states hold ad_out/trdy_n unchanged.
//  STOP_WAIT: trdy_n=1, stop_n=0, devsel_n=0 until an edge with frame_n=1 -> TURN.
//  TURN (1 clk): devsel_n=trdy_n=stop_n=1, ad_oe=0 -> IDLE. New address phase accepted from IDLE only.
//  Master abandon (frame_n=1 & irdy_n=1 in any data state) -> TURN; no SRAM write that edge.
//  sram_we is never 1 during reads; ad_oe is never 1 during writes.
// TESTING
//  1. MemWr @0x0000_0010, 1 phase, data 0xDEADBEEF, cbe_n=0
//     -> one sram_we pulse, sram_add=0x10, be=4'hF; devsel_n/trdy_n released after TURN.
//  2. MemWr burst 4 @0x20, cbe_n=4'b1100 on phase 2
//     -> sram_add 0x20,0x24,0x28,0x2C; phase 2 sram_be=4'b0011.
//  3. MemRd @0x20 after test 2 -> ad_out returns the 4 written words; TRDY# every 3rd clk;
//     an irdy_n wait state holds ad_out stable.
//  4. MemWr burst starting at word ADD_END-1 -> stop_n=0 with the 2nd TRDY#; only 2 writes;
//     STOP_WAIT until frame_n=1.
//  5. Address 0x0001_0000 (outside window) or cmd 4'b0010 -> devsel_n stays 1, no sram_we; BUSY->IDLE.
//  6. rst_n=0 mid read burst -> all outputs at reset values immediately; next MemRd succeeds.

Source files
------------

// File: rtl/pci_target_ctrl.sv
// PCI target sequencer for a single sram_32 word window: decodes MemRd/MemWr address phases,
// drives DEVSEL#/TRDY#/STOP# and turns burst data phases into SRAM word accesses.
module pci_target_ctrl #(
  parameter logic [29:0] ADD_START = 30'h0000_0000,
  parameter logic [29:0] ADD_END   = 30'h0000_03FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic [31:0] sram_add,
  output logic [31:0] sram_data,
  output logic [3:0]  sram_be,
  output logic        sram_we,
  input  logic [31:0] sram_q
);

  typedef enum logic [2:0] {
    StIdle, StWrData, StRdW1, StRdW2, StRdData, StStopWait, StTurn, StBusy
  } state_e;

  localparam logic [3:0] CmdMemRd = 4'b0110;
  localparam logic [3:0] CmdMemWr = 4'b0111;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        frame_prev_q;
  logic [31:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic        devsel_n_q, devsel_n_d;
  logic        trdy_n_q, trdy_n_d;
  logic        stop_n_q, stop_n_d;
  logic [31:0] sram_add_q, sram_add_d;
  logic [31:0] sram_data_q, sram_data_d;
  logic [3:0]  sram_be_q, sram_be_d;
  logic        sram_we_q, sram_we_d;

  logic [29:0] ad_word;
  logic [29:0] addr_inc;
  logic [30:0] lo_diff, hi_diff;
  logic        in_window, addr_start, at_end, next_end, abandon, go_turn;

  assign ad_word    = ad_in[31:2];
  assign addr_inc   = addr_q + 30'd1;
  // Window bounds via borrow bits so a zero ADD_START does not yield a constant compare.
  assign lo_diff    = {1'b0, ad_word} - {1'b0, ADD_START};
  assign hi_diff    = {1'b0, ADD_END} - {1'b0, ad_word};
  assign in_window  = !lo_diff[30] && !hi_diff[30];
  assign addr_start = !frame_n && frame_prev_q;
  assign at_end     = (addr_q == ADD_END);
  assign next_end   = (addr_inc == ADD_END);
  assign abandon    = frame_n && irdy_n;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ad_out_d    = ad_out_q;
    ad_oe_d     = ad_oe_q;
    devsel_n_d  = devsel_n_q;
    trdy_n_d    = trdy_n_q;
    stop_n_d    = stop_n_q;
    sram_add_d  = sram_add_q;
    sram_data_d = sram_data_q;
    sram_be_d   = sram_be_q;
    sram_we_d   = 1'b0;
    go_turn     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (addr_start) begin
          addr_d = ad_word;
          if (cbe_n == CmdMemWr && in_window) begin
            devsel_n_d = 1'b0;
            trdy_n_d   = 1'b0;
            stop_n_d   = (ad_word != ADD_END);
            state_d    = StWrData;
          end else if (cbe_n == CmdMemRd && in_window) begin
            devsel_n_d = 1'b0;
            sram_add_d = {ad_word, 2'b00};
            ad_oe_d    = 1'b1;
            state_d    = StRdW1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StWrData: begin
        if (abandon) begin
          go_turn = 1'b1;
        end else if (!irdy_n) begin
          sram_we_d   = 1'b1;
          sram_add_d  = {addr_q, 2'b00};
          sram_data_d = ad_in;
          sram_be_d   = ~cbe_n;
          addr_d      = addr_inc;
          if (frame_n) begin
            go_turn = 1'b1;
          end else if (at_end) begin
            trdy_n_d = 1'b1;
            state_d  = StStopWait;
          end else if (next_end) begin
            // STOP# accompanies the TRDY# of the last word in the window.
            stop_n_d = 1'b0;
          end
        end
      end
      StRdW1: begin
        if (abandon) go_turn = 1'b1;
        else         state_d = StRdW2;
      end
      StRdW2: begin
        if (abandon) begin
          go_turn = 1'b1;
        end else begin
          ad_out_d = sram_q;
          trdy_n_d = 1'b0;
          if (at_end) stop_n_d = 1'b0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (abandon) begin
          go_turn = 1'b1;
        end else if (!irdy_n) begin
          trdy_n_d = 1'b1;
          if (frame_n) begin
            go_turn = 1'b1;
          end else if (at_end) begin
            state_d = StStopWait;
          end else begin
            addr_d     = addr_inc;
            sram_add_d = {addr_inc, 2'b00};
            state_d    = StRdW1;
          end
        end
      end
      StStopWait: begin
        trdy_n_d   = 1'b1;
        stop_n_d   = 1'b0;
        devsel_n_d = 1'b0;
        if (frame_n) go_turn = 1'b1;
      end
      StTurn: state_d = StIdle;
      StBusy: begin
        if (abandon) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (go_turn) begin
      devsel_n_d = 1'b1;
      trdy_n_d   = 1'b1;
      stop_n_d   = 1'b1;
      ad_oe_d    = 1'b0;
      state_d    = StTurn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      frame_prev_q <= 1'b1;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      devsel_n_q   <= 1'b1;
      trdy_n_q     <= 1'b1;
      stop_n_q     <= 1'b1;
      sram_add_q   <= '0;
      sram_data_q  <= '0;
      sram_be_q    <= '0;
      sram_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      frame_prev_q <= frame_n;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      devsel_n_q   <= devsel_n_d;
      trdy_n_q     <= trdy_n_d;
      stop_n_q     <= stop_n_d;
      sram_add_q   <= sram_add_d;
      sram_data_q  <= sram_data_d;
      sram_be_q    <= sram_be_d;
      sram_we_q    <= sram_we_d;
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign devsel_n  = devsel_n_q;
  assign trdy_n    = trdy_n_q;
  assign stop_n    = stop_n_q;
  assign sram_add  = sram_add_q;
  assign sram_data = sram_data_q;
  assign sram_be   = sram_be_q;
  assign sram_we   = sram_we_q;

endmodule
